// File: rtl/forwarding_unit_if.sv
// Signal bundle between the EX stage and the forwarding unit.
// The pipeline side drives register numbers and data; the unit returns selects, operands and counters.
interface forwarding_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [4:0]        rs1_ID_EX;
    logic [4:0]        rs2_ID_EX;
    logic [4:0]        rd_EX_MEM;
    logic [4:0]        rd_MEM_WB;
    logic              RegWrite_EX_MEM;
    logic              RegWrite_MEM_WB;
    logic [DATA_W-1:0] rs1_data_ID_EX;
    logic [DATA_W-1:0] rs2_data_ID_EX;
    logic [DATA_W-1:0] alu_result_EX_MEM;
    logic [DATA_W-1:0] wb_data_MEM_WB;
    logic [1:0]        forwardA;
    logic [1:0]        forwardB;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [CNT_W-1:0]  fwd_exmem_count;
    logic [CNT_W-1:0]  fwd_memwb_count;

    modport master (
        output rs1_ID_EX, rs2_ID_EX, rd_EX_MEM, rd_MEM_WB,
        output RegWrite_EX_MEM, RegWrite_MEM_WB,
        output rs1_data_ID_EX, rs2_data_ID_EX, alu_result_EX_MEM, wb_data_MEM_WB,
        input  forwardA, forwardB, operand_a, operand_b,
        input  fwd_exmem_count, fwd_memwb_count
    );

    modport slave (
        input  rs1_ID_EX, rs2_ID_EX, rd_EX_MEM, rd_MEM_WB,
        input  RegWrite_EX_MEM, RegWrite_MEM_WB,
        input  rs1_data_ID_EX, rs2_data_ID_EX, alu_result_EX_MEM, wb_data_MEM_WB,
        output forwardA, forwardB, operand_a, operand_b,
        output fwd_exmem_count, fwd_memwb_count
    );
endinterface

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding: combinational operand selects and muxes,
// plus saturating counters of how often each pipeline stage supplied an operand.
module forwarding_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    forwarding_unit_if.slave  bus
);
    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [CNT_W:0] SAT_MAX = {1'b0, {CNT_W{1'b1}}};

    // EX/MEM is checked first because it holds the newer value of a doubly-written register.
    function automatic logic [1:0] selectFor(
        input logic [4:0] rs,
        input logic [4:0] rdExMem,
        input logic       wrExMem,
        input logic [4:0] rdMemWb,
        input logic       wrMemWb
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (wrExMem && (rdExMem != 5'd0) && (rdExMem == rs)) begin
            sel = SEL_EXMEM;
        end else if (wrMemWb && (rdMemWb != 5'd0) && (rdMemWb == rs)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] satAdd(
        input logic [CNT_W-1:0] count,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, count} + (CNT_W+1)'(inc);
        return (sum > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    endfunction

    logic [1:0]        w_forwardA;
    logic [1:0]        w_forwardB;
    logic [DATA_W-1:0] w_operandA;
    logic [DATA_W-1:0] w_operandB;
    logic [1:0]        w_exmemInc;
    logic [1:0]        w_memwbInc;
    logic [CNT_W-1:0]  r_fwdExmemCount;
    logic [CNT_W-1:0]  r_fwdMemwbCount;

    always_comb begin
        w_forwardA = selectFor(bus.rs1_ID_EX, bus.rd_EX_MEM, bus.RegWrite_EX_MEM,
                               bus.rd_MEM_WB, bus.RegWrite_MEM_WB);
        w_forwardB = selectFor(bus.rs2_ID_EX, bus.rd_EX_MEM, bus.RegWrite_EX_MEM,
                               bus.rd_MEM_WB, bus.RegWrite_MEM_WB);
    end

    always_comb begin
        w_operandA = bus.rs1_data_ID_EX;
        case (w_forwardA)
            SEL_EXMEM: w_operandA = bus.alu_result_EX_MEM;
            SEL_MEMWB: w_operandA = bus.wb_data_MEM_WB;
            default:   w_operandA = bus.rs1_data_ID_EX;
        endcase
        w_operandB = bus.rs2_data_ID_EX;
        case (w_forwardB)
            SEL_EXMEM: w_operandB = bus.alu_result_EX_MEM;
            SEL_MEMWB: w_operandB = bus.wb_data_MEM_WB;
            default:   w_operandB = bus.rs2_data_ID_EX;
        endcase
    end

    // Each operand contributes at most one event per cycle, so increments are 0..2.
    always_comb begin
        w_exmemInc = {1'b0, w_forwardA == SEL_EXMEM} + {1'b0, w_forwardB == SEL_EXMEM};
        w_memwbInc = {1'b0, w_forwardA == SEL_MEMWB} + {1'b0, w_forwardB == SEL_MEMWB};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwdExmemCount <= '0;
            r_fwdMemwbCount <= '0;
        end else begin
            r_fwdExmemCount <= satAdd(r_fwdExmemCount, w_exmemInc);
            r_fwdMemwbCount <= satAdd(r_fwdMemwbCount, w_memwbInc);
        end
    end

    assign bus.forwardA        = w_forwardA;
    assign bus.forwardB        = w_forwardB;
    assign bus.operand_a       = w_operandA;
    assign bus.operand_b       = w_operandB;
    assign bus.fwd_exmem_count = r_fwdExmemCount;
    assign bus.fwd_memwb_count = r_fwdMemwbCount;
endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: a 16-bit-counter instance and a 2-bit-counter instance share
// the same stimulus; directed vectors, random vectors and a saturation/reset sequence.
module tb_forwarding_unit;
    localparam int BIG_MAX   = 65535;
    localparam int SMALL_MAX = 3;

    logic clk;
    logic rst_n;

    logic [4:0]  curRs1, curRs2, curRdEm, curRdMw;
    logic        curRwEm, curRwMw;
    logic [31:0] curRs1Data, curRs2Data, curAlu, curWb;

    int total = 0;
    int bad   = 0;
    int mBigEm = 0, mBigMw = 0, mSmallEm = 0, mSmallMw = 0;

    forwarding_unit_if #(.DATA_W(32), .CNT_W(16)) bigIf ();
    forwarding_unit_if #(.DATA_W(32), .CNT_W(2))  smallIf ();

    forwarding_unit #(.DATA_W(32), .CNT_W(16)) dutBig (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bigIf)
    );

    forwarding_unit #(.DATA_W(32), .CNT_W(2)) dutSmall (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (smallIf)
    );

    assign bigIf.rs1_ID_EX         = curRs1;
    assign bigIf.rs2_ID_EX         = curRs2;
    assign bigIf.rd_EX_MEM         = curRdEm;
    assign bigIf.rd_MEM_WB         = curRdMw;
    assign bigIf.RegWrite_EX_MEM   = curRwEm;
    assign bigIf.RegWrite_MEM_WB   = curRwMw;
    assign bigIf.rs1_data_ID_EX    = curRs1Data;
    assign bigIf.rs2_data_ID_EX    = curRs2Data;
    assign bigIf.alu_result_EX_MEM = curAlu;
    assign bigIf.wb_data_MEM_WB    = curWb;

    assign smallIf.rs1_ID_EX         = curRs1;
    assign smallIf.rs2_ID_EX         = curRs2;
    assign smallIf.rd_EX_MEM         = curRdEm;
    assign smallIf.rd_MEM_WB         = curRdMw;
    assign smallIf.RegWrite_EX_MEM   = curRwEm;
    assign smallIf.RegWrite_MEM_WB   = curRwMw;
    assign smallIf.rs1_data_ID_EX    = curRs1Data;
    assign smallIf.rs2_data_ID_EX    = curRs2Data;
    assign smallIf.alu_result_EX_MEM = curAlu;
    assign smallIf.wb_data_MEM_WB    = curWb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rdEm, rdMw;
        logic       rwEm, rwMw;
        logic [1:0] expA, expB;
    } vec_t;

    // Reference: which stage supplies a source register (2 = EX/MEM, 1 = MEM/WB, 0 = file).
    function automatic int modelSrc(input int rs);
        if (rs == 0) return 0;
        if (curRwEm && int'(curRdEm) == rs) return 2;
        if (curRwMw && int'(curRdMw) == rs) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        curRs1 = v.rs1;  curRs2 = v.rs2;
        curRdEm = v.rdEm; curRdMw = v.rdMw;
        curRwEm = v.rwEm; curRwMw = v.rwMw;
        curRs1Data = $urandom; curRs2Data = $urandom;
        curAlu = $urandom;     curWb = $urandom;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] expA, input logic [1:0] expB);
        logic [31:0] opA, opB;
        opA = (expA == 2'b10) ? curAlu : (expA == 2'b01) ? curWb : curRs1Data;
        opB = (expB == 2'b10) ? curAlu : (expB == 2'b01) ? curWb : curRs2Data;
        check({tag, " forwardA"}, 64'(bigIf.forwardA), 64'(expA));
        check({tag, " forwardB"}, 64'(bigIf.forwardB), 64'(expB));
        check({tag, " operand_a"}, 64'(bigIf.operand_a), 64'(opA));
        check({tag, " operand_b"}, 64'(bigIf.operand_b), 64'(opB));
        check({tag, " small forwardA"}, 64'(smallIf.forwardA), 64'(expA));
        check({tag, " small forwardB"}, 64'(smallIf.forwardB), 64'(expB));
    endtask

    // One clock: advance the counter model from the selects in force before the edge.
    task automatic tick(input string tag);
        int sA, sB, nEm, nMw;
        sA = modelSrc(int'(curRs1));
        sB = modelSrc(int'(curRs2));
        nEm = int'(sA == 2) + int'(sB == 2);
        nMw = int'(sA == 1) + int'(sB == 1);
        @(posedge clk);
        if (!rst_n) begin
            mBigEm = 0; mBigMw = 0; mSmallEm = 0; mSmallMw = 0;
        end else begin
            mBigEm   = sat(mBigEm + nEm, BIG_MAX);
            mBigMw   = sat(mBigMw + nMw, BIG_MAX);
            mSmallEm = sat(mSmallEm + nEm, SMALL_MAX);
            mSmallMw = sat(mSmallMw + nMw, SMALL_MAX);
        end
        #1;
        check({tag, " exmem_count"}, 64'(bigIf.fwd_exmem_count), 64'(mBigEm));
        check({tag, " memwb_count"}, 64'(bigIf.fwd_memwb_count), 64'(mBigMw));
        check({tag, " small exmem_count"}, 64'(smallIf.fwd_exmem_count), 64'(mSmallEm));
        check({tag, " small memwb_count"}, 64'(smallIf.fwd_memwb_count), 64'(mSmallMw));
    endtask

    vec_t table_q[$];

    initial begin
        vec_t v;
        int sA, sB;

        table_q.push_back('{rs1:0, rs2:0, rdEm:0, rdMw:0, rwEm:0, rwMw:0, expA:2'b00, expB:2'b00});
        table_q.push_back('{rs1:5, rs2:6, rdEm:5, rdMw:6, rwEm:1, rwMw:1, expA:2'b10, expB:2'b01});
        table_q.push_back('{rs1:3, rs2:4, rdEm:0, rdMw:0, rwEm:0, rwMw:0, expA:2'b00, expB:2'b00});
        table_q.push_back('{rs1:5, rs2:6, rdEm:5, rdMw:5, rwEm:1, rwMw:1, expA:2'b10, expB:2'b00});
        table_q.push_back('{rs1:0, rs2:0, rdEm:0, rdMw:0, rwEm:1, rwMw:1, expA:2'b00, expB:2'b00});
        table_q.push_back('{rs1:7, rs2:1, rdEm:7, rdMw:2, rwEm:0, rwMw:1, expA:2'b00, expB:2'b00});
        table_q.push_back('{rs1:8, rs2:8, rdEm:8, rdMw:8, rwEm:1, rwMw:1, expA:2'b10, expB:2'b10});
        table_q.push_back('{rs1:12, rs2:12, rdEm:3, rdMw:12, rwEm:1, rwMw:1, expA:2'b01, expB:2'b01});
        table_q.push_back('{rs1:31, rs2:30, rdEm:30, rdMw:31, rwEm:1, rwMw:1, expA:2'b01, expB:2'b10});
        table_q.push_back('{rs1:9, rs2:9, rdEm:9, rdMw:9, rwEm:0, rwMw:1, expA:2'b01, expB:2'b01});

        rst_n = 1'b0;
        applyStimulus(table_q[0]);
        tick("reset1");
        tick("reset2");
        check("reset exmem_count", 64'(bigIf.fwd_exmem_count), 64'd0);
        check("reset memwb_count", 64'(bigIf.fwd_memwb_count), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            checkOutput($sformatf("vec%0d", i), table_q[i].expA, table_q[i].expB);
            tick($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            v.rs1  = 5'($urandom_range(0, 7));
            v.rs2  = 5'($urandom_range(0, 7));
            v.rdEm = 5'($urandom_range(0, 7));
            v.rdMw = 5'($urandom_range(0, 7));
            v.rwEm = 1'($urandom_range(0, 1));
            v.rwMw = 1'($urandom_range(0, 1));
            v.expA = 2'b00;
            v.expB = 2'b00;
            applyStimulus(v);
            sA = modelSrc(int'(curRs1));
            sB = modelSrc(int'(curRs2));
            checkOutput($sformatf("rand%0d", i), 2'(sA), 2'(sB));
            tick($sformatf("rand%0d", i));
        end

        // Saturation of the 2-bit counters, then a mid-run reset.
        rst_n = 1'b0;
        tick("satclr");
        rst_n = 1'b1;
        applyStimulus('{rs1:9, rs2:9, rdEm:9, rdMw:0, rwEm:1, rwMw:0, expA:2'b10, expB:2'b10});
        tick("sat1");
        check("sat1 small exmem const", 64'(smallIf.fwd_exmem_count), 64'd2);
        tick("sat2");
        check("sat2 small exmem const", 64'(smallIf.fwd_exmem_count), 64'd3);
        tick("sat3");
        check("sat3 small exmem const", 64'(smallIf.fwd_exmem_count), 64'd3);
        check("sat3 big exmem const", 64'(bigIf.fwd_exmem_count), 64'd6);
        rst_n = 1'b0;
        tick("midreset");
        check("midreset small exmem const", 64'(smallIf.fwd_exmem_count), 64'd0);
        check("midreset big exmem const", 64'(bigIf.fwd_exmem_count), 64'd0);
        checkOutput("midreset", 2'b10, 2'b10);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Data-hazard forwarding unit for the 5-stage MIPS pipeline; sits in the EX stage.
- Compares the ID/EX source register numbers against the destination registers held in EX/MEM and MEM/WB.
- Produces the 2-bit ALU-operand mux selects and the forwarded operand values.
- Keeps saturating clocked counters of forwarding events for performance monitoring.

Parameters:
- DATA_W, 32, operand/result data width.
- CNT_W, 16, width of each forwarding event counter.

Ports:
- clk  in  1  system clock; counters update on rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on rising clk.
- rs1_ID_EX  in  5  source register 1 number of the instruction in EX.
- rs2_ID_EX  in  5  source register 2 number of the instruction in EX.
- rd_EX_MEM  in  5  destination register of the instruction in MEM.
- rd_MEM_WB  in  5  destination register of the instruction in WB.
- RegWrite_EX_MEM  in  1  MEM-stage instruction writes the register file.
- RegWrite_MEM_WB  in  1  WB-stage instruction writes the register file.
- rs1_data_ID_EX  in  DATA_W  register-file value of rs1.
- rs2_data_ID_EX  in  DATA_W  register-file value of rs2.
- alu_result_EX_MEM  in  DATA_W  result held in EX/MEM.
- wb_data_MEM_WB  in  DATA_W  write-back value held in MEM/WB.
- forwardA  out  2  operand A select.
- forwardB  out  2  operand B select.
- operand_a  out  DATA_W  forwarded operand A.
- operand_b  out  DATA_W  forwarded operand B.
- fwd_exmem_count  out  CNT_W  count of operands forwarded from EX/MEM.
- fwd_memwb_count  out  CNT_W  count of operands forwarded from MEM/WB.

Behaviour:
- Select encoding: 2'b00 = register file (no forward); 2'b10 = EX/MEM; 2'b01 = MEM/WB; 2'b11 is never driven.
- forwardA is purely combinational, with no clock latency and unaffected by rst_n. It is evaluated in priority order:
  - 2'b10 if RegWrite_EX_MEM=1, rd_EX_MEM!=0 and rd_EX_MEM==rs1_ID_EX.
  - Otherwise 2'b01 if RegWrite_MEM_WB=1, rd_MEM_WB!=0 and rd_MEM_WB==rs1_ID_EX.
  - Otherwise 2'b00.
- forwardB uses the identical rule with rs2_ID_EX.
- Double hazard: when both stages match the same source, EX/MEM wins, because it holds the newer value.
- Register $0 is never forwarded, regardless of RegWrite.
- A RegWrite of 0 suppresses forwarding from that stage even if the register numbers match.
- rs1 and rs2 are evaluated independently. Both may forward from the same stage, or from different stages, in the same cycle.
- Operand muxes (combinational): operand_a = alu_result_EX_MEM when 10, wb_data_MEM_WB when 01, rs1_data_ID_EX when 00. operand_b is the same using forwardB and rs2_data_ID_EX.
- Counters:
  - While rst_n=0 at a rising edge, both counters load 0.
  - Otherwise, on each rising edge, fwd_exmem_count adds the number of selects equal to 10 (0, 1 or 2).
  - fwd_memwb_count likewise adds the number of selects equal to 01.
  - Both counters saturate at 2^CNT_W-1, with no wrap; an increment of 2 at max-1 yields max.
  - Reset mid-operation clears the counters on that edge; the combinational outputs keep tracking inputs throughout.
- No X propagation: every output is defined for all input combinations.

Test Plan:
- All inputs 0, RegWrite both 0 -> forwardA=00, forwardB=00, operand_a=rs1_data_ID_EX, operand_b=rs2_data_ID_EX.
- rs1=5, rs2=6, rd_EX_MEM=5, rd_MEM_WB=6, both RegWrite=1 -> forwardA=10, forwardB=01, operand_a=alu_result_EX_MEM, operand_b=wb_data_MEM_WB; after one clock, each counter has advanced by 1.
- rs1=3, rs2=4, rd_EX_MEM=0, rd_MEM_WB=0, RegWrite=0 -> forwardA=00, forwardB=00; counters unchanged.
- Double hazard: rs1=5, rs2=6, rd_EX_MEM=5, rd_MEM_WB=5, both RegWrite=1 -> forwardA=10, forwardB=00.
- rs1=0, rs2=0, rd_EX_MEM=0, rd_MEM_WB=0, both RegWrite=1 -> both selects 00. Separately, rs1=7, rd_EX_MEM=7, RegWrite_EX_MEM=0 -> forwardA=00.
- Counter check with CNT_W=2:
  - rs1=rs2=9, rd_EX_MEM=9, RegWrite_EX_MEM=1, held for 3 clocks -> fwd_exmem_count = 2, then 3, then 3 (saturated).
  - Then rst_n=0 for one clock -> both counters read 0 after that edge, while forwardA and forwardB stay 10.
